// File: rtl/early_stage_predecode_queue.sv
// Fetch-stage predecoder: per-slot immediate, type, control-flow flags and target into a FIFO.
// Optional `PREDECODE_TARGET_EN builds the per-slot target adders and target storage.
module early_stage_predecode_queue #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [DATA_WIDTH-1:0]             in_pc_i,
  input  logic [32*FETCH_WIDTH-1:0]         in_instr_i,
  input  logic [FETCH_WIDTH-1:0]            in_slot_valid_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_WIDTH-1:0]             out_pc_o,
  output logic [32*FETCH_WIDTH-1:0]         out_instr_o,
  output logic [FETCH_WIDTH-1:0]            out_slot_valid_o,
  output logic [DATA_WIDTH*FETCH_WIDTH-1:0] out_imm_o,
  output logic [3*FETCH_WIDTH-1:0]          out_imm_type_o,
  output logic [FETCH_WIDTH-1:0]            out_is_branch_o,
  output logic [FETCH_WIDTH-1:0]            out_is_jal_o,
  output logic [FETCH_WIDTH-1:0]            out_is_jalr_o,
  output logic [DATA_WIDTH*FETCH_WIDTH-1:0] out_target_o,
  output logic [$clog2(DEPTH):0]            count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [2:0] TyI    = 3'd0;
  localparam logic [2:0] TyS    = 3'd1;
  localparam logic [2:0] TyB    = 3'd2;
  localparam logic [2:0] TyU    = 3'd3;
  localparam logic [2:0] TyJ    = 3'd4;
  localparam logic [2:0] TyNone = 3'd7;

  logic [DATA_WIDTH*FETCH_WIDTH-1:0] dec_imm;
  logic [3*FETCH_WIDTH-1:0]          dec_type;
  logic [FETCH_WIDTH-1:0]            dec_br, dec_jal, dec_jalr;
`ifdef PREDECODE_TARGET_EN
  logic [DATA_WIDTH*FETCH_WIDTH-1:0] dec_target;
`endif

  always_comb begin
    logic [31:0]           instr;
    logic [31:0]           imm32;
    logic [2:0]            ty;
    logic [DATA_WIDTH-1:0] imm;
    dec_imm  = '0;
    dec_type = '0;
    dec_br   = '0;
    dec_jal  = '0;
    dec_jalr = '0;
`ifdef PREDECODE_TARGET_EN
    dec_target = '0;
`endif
    for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
      instr = in_instr_i[32*k +: 32];
      imm32 = '0;
      ty    = TyNone;
      if (in_slot_valid_i[k]) begin
        case (instr[6:0])
          7'b0000011, 7'b0010011: begin
            ty    = TyI;
            imm32 = {{20{instr[31]}}, instr[31:20]};
          end
          7'b1100111: begin
            ty          = TyI;
            imm32       = {{20{instr[31]}}, instr[31:20]};
            dec_jalr[k] = 1'b1;
          end
          7'b0100011: begin
            ty    = TyS;
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          end
          7'b1100011: begin
            ty        = TyB;
            imm32     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            dec_br[k] = 1'b1;
          end
          7'b0110111, 7'b0010111: begin
            ty    = TyU;
            imm32 = {instr[31:12], 12'b0};
          end
          7'b1101111: begin
            ty         = TyJ;
            imm32      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            dec_jal[k] = 1'b1;
          end
          default: ty = TyNone;
        endcase
      end
      // Every RV32I immediate already carries instr[31] in bit 31, so a signed widen suffices.
      imm = DATA_WIDTH'($signed(imm32));
      dec_imm[DATA_WIDTH*k +: DATA_WIDTH] = imm;
      dec_type[3*k +: 3] = ty;
`ifdef PREDECODE_TARGET_EN
      if (dec_br[k] || dec_jal[k]) begin
        dec_target[DATA_WIDTH*k +: DATA_WIDTH] = in_pc_i + DATA_WIDTH'(4 * k) + imm;
      end
`endif
    end
  end

  logic [DATA_WIDTH-1:0]             pc_q       [DEPTH];
  logic [32*FETCH_WIDTH-1:0]         instr_q    [DEPTH];
  logic [FETCH_WIDTH-1:0]            slot_vld_q [DEPTH];
  logic [DATA_WIDTH*FETCH_WIDTH-1:0] imm_q      [DEPTH];
  logic [3*FETCH_WIDTH-1:0]          type_q     [DEPTH];
  logic [FETCH_WIDTH-1:0]            br_q       [DEPTH];
  logic [FETCH_WIDTH-1:0]            jal_q      [DEPTH];
  logic [FETCH_WIDTH-1:0]            jalr_q     [DEPTH];
`ifdef PREDECODE_TARGET_EN
  logic [DATA_WIDTH*FETCH_WIDTH-1:0] target_q   [DEPTH];
`endif
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  assign in_ready_o  = (count_q != CntW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]       <= '0;
        instr_q[i]    <= '0;
        slot_vld_q[i] <= '0;
        imm_q[i]      <= '0;
        type_q[i]     <= '0;
        br_q[i]       <= '0;
        jal_q[i]      <= '0;
        jalr_q[i]     <= '0;
`ifdef PREDECODE_TARGET_EN
        target_q[i]   <= '0;
`endif
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]       <= in_pc_i;
        instr_q[wr_ptr_q]    <= in_instr_i;
        slot_vld_q[wr_ptr_q] <= in_slot_valid_i;
        imm_q[wr_ptr_q]      <= dec_imm;
        type_q[wr_ptr_q]     <= dec_type;
        br_q[wr_ptr_q]       <= dec_br;
        jal_q[wr_ptr_q]      <= dec_jal;
        jalr_q[wr_ptr_q]     <= dec_jalr;
`ifdef PREDECODE_TARGET_EN
        target_q[wr_ptr_q]   <= dec_target;
`endif
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign out_pc_o         = pc_q[rd_ptr_q];
  assign out_instr_o      = instr_q[rd_ptr_q];
  assign out_slot_valid_o = slot_vld_q[rd_ptr_q];
  assign out_imm_o        = imm_q[rd_ptr_q];
  assign out_imm_type_o   = type_q[rd_ptr_q];
  assign out_is_branch_o  = br_q[rd_ptr_q];
  assign out_is_jal_o     = jal_q[rd_ptr_q];
  assign out_is_jalr_o    = jalr_q[rd_ptr_q];
`ifdef PREDECODE_TARGET_EN
  assign out_target_o     = target_q[rd_ptr_q];
`else
  assign out_target_o     = '0;
`endif
  assign count_o          = count_q;

endmodule
